fetch_execute_unit: RTL and testbench
=====================================

// Module: fetch_execute_unit
// PURPOSE
//   Multi-cycle fetch/decode/execute controller for the 8-bit-instruction nibble CPU. Consumes the instruction
//   memory: drives its 5-bit address (PC) and latches its combinational 8-bit data. Decodes {op[7:5], I[4], k[3:0]},
//   owns ACC, carry and PC, and drives the 16x4 data memory. Stops on HALT.
// PARAMETERS
//   PC_W    5  program counter / instruction address width (wraps modulo 2**PC_W)
//   DW      4  accumulator, operand and data-memory word width
//   DAW     4  data-memory address width (the operand k)
// PORTS
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   run         in   1      1 = allowed to leave FETCH; 0 = hold in FETCH, no state change
//   imem_addr   out  PC_W   instruction address (= PC register)
//   imem_data   in   8      instruction word, combinational from imem_addr
//   dmem_addr   out  DAW    data-memory address (= IR[3:0] in EXEC/MEMRD, else 0)
//   dmem_wdata  out  DW     write data (= ACC)
//   dmem_we     out  1      write strobe, one cycle, in EXEC for STA only
//   dmem_rdata  in   DW     read data, synchronous: valid the cycle after dmem_addr is presented
//   acc         out  DW     accumulator
//   carry       out  1      carry flag
//   halted      out  1      1 while in HALT state
// BEHAVIOUR
//   Reset (async, rst_n=0): PC=0, IR=0, ACC=0, carry=0, state=FETCH, dmem_we=0, halted=0.
//   States: FETCH -> EXEC -> (MEMRD) -> FETCH; HALT is terminal until reset.
//   FETCH: if run: IR<=imem_data, PC<=PC+1 (31 wraps to 0), ->EXEC. If !run: hold everything.
//   EXEC, decode op/I (k = IR[3:0]; z = (ACC==0)):
//     000 I=0 STA k   dmem_we=1, dmem_addr=k, wdata=ACC; ->FETCH
//     000 I=1 HALT    ->HALT (PC left at HALT address+1)
//     001 LDA         I=1: ACC<=k, ->FETCH; I=0: ->MEMRD
//     010 ADC         I=1: {carry,ACC}<=ACC+k+carry, ->FETCH; I=0: ->MEMRD
//     011 NOR         I=1: ACC<=~(ACC|k), carry unchanged, ->FETCH; I=0: ->MEMRD
//     100 SETC        carry<=I; k ignored; ->FETCH
//     101 JNZ k       if !z: PC<={1'b0,k}; ->FETCH
//     110 JNC k       if !carry: PC<={1'b0,k}; ->FETCH
//     111 JMP k       PC<={1'b0,k}; ->FETCH
//   MEMRD: same ALU op using dmem_rdata as operand; ->FETCH.
//   Latency: immediate/jump/STA/SETC = 2 cycles; memory-operand LDA/ADC/NOR = 3 cycles.
//   ADC sum is DW+1 bits; the MSB becomes carry. Only ADC and SETC write carry.
//   Jump targets reach 0x00-0x0F only; the PC increment still reaches 0x10-0x1F.
//   Jumps in EXEC override the increment done in FETCH.
//   run only gates FETCH; an instruction in EXEC/MEMRD completes regardless.
//   HALT: all registers frozen, dmem_we=0, halted=1; run ignored.
//   Reset mid-instruction aborts it; no partial write (dmem_we clears asynchronously).
//   Instruction memory returns 0x00 (STA 0x0) for unmapped addresses; these execute normally.
// STRUCTURE
//   Shared include nibble_isa.vh: opcode localparams OP_STA_HALT..OP_JMP, field slices
//   (OP=7:5, IMM=4, K=3:0), FSM state encodings.
//   One sub-module: nibble_alu (combinational: op, a, b, cin -> y, cout; covers LDA/ADC/NOR).
//   This block holds the FSM, PC, IR, ACC and carry registers.
// TESTING
//   1 reset: rst_n low mid-EXEC of STA -> dmem_we=0 immediately; PC=0, ACC=0, carry=0, halted=0.
//   2 ADC #1 with ACC=0xF, carry=0 -> ACC=0x0, carry=1, 2 cycles; then JNZ 0x0 not taken -> PC=2.
//   3 STA 0x8 with ACC=0xA -> one dmem_we pulse, addr=8, wdata=0xA; then LDA (0x8) -> ACC=0xA after 3 cycles.
//   4 NOR (0xF) with mem[F]=0x3, ACC=0x4 -> ACC=0x8, carry unchanged.
//   5 SETC 0; JNC 0x5 -> PC=5; SETC 1; JNC 0x5 -> falls through, PC=+1.
//   6 run=0 in FETCH for 10 cycles -> no register changes; HALT at 0xD -> halted=1, PC=0xE frozen.
//   7 PC wrap: 31 sequential non-jumps from 0 -> PC wraps 0x1F->0x00.

Source files
------------

// File: rtl/fetch_execute_unit_pkg.sv
// rtl/fetch_execute_unit_pkg.sv - nibble CPU ISA encodings, field slices and FSM states
package fetch_execute_unit_pkg;

    localparam int PC_W_DEF = 5;
    localparam int DW_DEF   = 4;
    localparam int DAW_DEF  = 4;

    // Instruction fields: {op[7:5], imm[4], k[3:0]}
    localparam int F_OP_HI  = 7;
    localparam int F_OP_LO  = 5;
    localparam int F_IMM    = 4;
    localparam int F_K_HI   = 3;
    localparam int F_K_LO   = 0;

    typedef enum logic [2:0] {
        OP_STA_HALT = 3'b000,
        OP_LDA      = 3'b001,
        OP_ADC      = 3'b010,
        OP_NOR      = 3'b011,
        OP_SETC     = 3'b100,
        OP_JNZ      = 3'b101,
        OP_JNC      = 3'b110,
        OP_JMP      = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_MEMRD = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

endpackage

// File: rtl/fetch_execute_unit_alu.sv
// rtl/fetch_execute_unit_alu.sv - combinational ALU for LDA/ADC/NOR
module nibble_alu
    import fetch_execute_unit_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  opcode_e       op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          cin_i,
    output logic [DW-1:0] y_o,
    output logic          cout_o
);

    logic [DW:0] sum;

    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, cin_i};
        y_o    = a_i;
        cout_o = cin_i;
        case (op_i)
            OP_LDA: y_o = b_i;
            OP_ADC: {cout_o, y_o} = sum;
            OP_NOR: y_o = ~(a_i | b_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_execute_unit.sv
// rtl/fetch_execute_unit.sv - multi-cycle fetch/decode/execute controller of the nibble CPU
module fetch_execute_unit
    import fetch_execute_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int DW   = DW_DEF,
    parameter int DAW  = DAW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    output logic [DAW-1:0]  dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    output logic            dmem_we,
    input  logic [DW-1:0]   dmem_rdata,
    output logic [DW-1:0]   acc,
    output logic            carry,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic            carry_q, carry_d;

    opcode_e         op;
    logic            imm;
    logic [DAW-1:0]  k;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_y;
    logic            alu_cout;

    assign op    = opcode_e'(ir_q[F_OP_HI:F_OP_LO]);
    assign imm   = ir_q[F_IMM];
    assign k     = ir_q[F_K_HI:F_K_LO];
    // Memory operand arrives one cycle after the address, i.e. in MEMRD
    assign alu_b = (state_q == ST_MEMRD) ? dmem_rdata : DW'(k);

    nibble_alu #(.DW(DW)) u_alu (
        .op_i   (op),
        .a_i    (acc_q),
        .b_i    (alu_b),
        .cin_i  (carry_q),
        .y_o    (alu_y),
        .cout_o (alu_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        dmem_we = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_STA_HALT: begin
                        if (imm) state_d = ST_HALT;
                        else     dmem_we = 1'b1;
                    end
                    OP_LDA, OP_ADC, OP_NOR: begin
                        if (imm) begin
                            acc_d   = alu_y;
                            carry_d = alu_cout;
                        end else begin
                            state_d = ST_MEMRD;
                        end
                    end
                    OP_SETC: carry_d = imm;
                    // Jump targets only reach the lower half of the address space
                    OP_JNZ:  if (acc_q != '0) pc_d = PC_W'(k);
                    OP_JNC:  if (!carry_q)    pc_d = PC_W'(k);
                    OP_JMP:  pc_d = PC_W'(k);
                    default: ;
                endcase
            end
            ST_MEMRD: begin
                acc_d   = alu_y;
                carry_d = alu_cout;
                state_d = ST_FETCH;
            end
            default: ;
        endcase
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = (state_q == ST_EXEC || state_q == ST_MEMRD) ? k : '0;
    assign dmem_wdata = acc_q;
    assign acc        = acc_q;
    assign carry      = carry_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_execute_unit.sv
// tb/tb_fetch_execute_unit.sv - self-checking bench with instruction-level reference model
module tb_fetch_execute_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [4:0] imem_addr;
    logic [7:0] imem_data;
    logic [3:0] dmem_addr;
    logic [3:0] dmem_wdata;
    logic       dmem_we;
    logic [3:0] dmem_rdata;
    logic [3:0] acc;
    logic       carry;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] imem [32];
    logic [3:0] dmem [16];
    logic       mem_clr;
    int         we_cnt;

    always #5 clk = ~clk;

    fetch_execute_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata),
        .acc        (acc),
        .carry      (carry),
        .halted     (halted)
    );

    assign imem_data = imem[imem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 4'h0;
        end else if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
        dmem_rdata <= dmem[dmem_addr];
    end

    always @(negedge clk) begin
        if (!rst_n)       we_cnt = 0;
        else if (dmem_we) we_cnt = we_cnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: executes a whole instruction at its fetch edge, then
    // reveals the architectural result once its latency has elapsed.
    logic [4:0] m_pc, p_pc;
    logic [3:0] m_acc, p_acc;
    logic       m_c, p_c, m_halt, p_halt;
    logic       m_we;
    logic [3:0] m_waddr, m_wdata;
    logic [3:0] shadow [16];
    int         busy;
    logic [7:0] ins;
    logic [2:0] mop;
    logic       mib;
    logic [3:0] mk, opnd;
    logic [4:0] msum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_acc = 0; m_c = 0; m_halt = 0; m_we = 0; busy = 0;
            for (int i = 0; i < 16; i++) shadow[i] = 4'h0;
        end else begin
            m_we = 0;
            if (busy > 0) begin
                busy = busy - 1;
                if (busy == 0) begin
                    m_pc = p_pc; m_acc = p_acc; m_c = p_c; m_halt = p_halt;
                end
            end else if (!m_halt && run) begin
                ins  = imem[m_pc];
                m_pc = m_pc + 5'd1;
                mop  = ins[7:5];
                mib  = ins[4];
                mk   = ins[3:0];
                p_pc = m_pc; p_acc = m_acc; p_c = m_c; p_halt = 0;
                opnd = mib ? mk : shadow[mk];
                busy = (mop >= 3'd1 && mop <= 3'd3 && !mib) ? 2 : 1;
                case (mop)
                    3'd0: if (mib) p_halt = 1;
                          else begin
                              m_we = 1; m_waddr = mk; m_wdata = m_acc; shadow[mk] = m_acc;
                          end
                    3'd1: p_acc = opnd;
                    3'd2: begin
                        msum = {1'b0, m_acc} + {1'b0, opnd} + {4'b0, m_c};
                        p_acc = msum[3:0]; p_c = msum[4];
                    end
                    3'd3: p_acc = ~(m_acc | opnd);
                    3'd4: p_c = mib;
                    3'd5: if (m_acc != 0) p_pc = {1'b0, mk};
                    3'd6: if (!m_c) p_pc = {1'b0, mk};
                    default: p_pc = {1'b0, mk};
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("pc", imem_addr, m_pc);
            chk("acc", acc, m_acc);
            chk("carry", carry, m_c);
            chk("halted", halted, m_halt);
            chk("dmem_we", dmem_we, m_we);
            if (m_we) begin
                chk("dmem_addr", dmem_addr, m_waddr);
                chk("dmem_wdata", dmem_wdata, m_wdata);
            end
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        mem_clr = 1'b1;
        for (int i = 0; i < 32; i++) imem[i] = 8'h00;
        @(negedge clk);
        mem_clr = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b1;
        mem_clr = 1'b0;
        for (int i = 0; i < 32; i++) imem[i] = 8'h00;

        // Reset during EXEC of STA must kill the write strobe at once
        hold_reset();
        chk("rst_pc", imem_addr, 0);
        chk("rst_we", dmem_we, 0);
        imem[0] = 8'h3A;
        imem[1] = 8'h05;
        release_reset();
        cycles(3);
        chk("sta_we_before_rst", dmem_we, 1);
        chk("sta_addr_before_rst", dmem_addr, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("async_we", dmem_we, 0);
        chk("async_pc", imem_addr, 0);
        chk("async_acc", acc, 0);
        chk("async_carry", carry, 0);
        chk("async_halted", halted, 0);
        cycles(1);
        chk("no_partial_write", dmem[5], 0);

        // ALU, store/load, NOR, carry-conditional jumps, run gating, halt
        hold_reset();
        imem[0]  = 8'h3F; imem[1]  = 8'h51; imem[2]  = 8'hA0; imem[3]  = 8'h3A;
        imem[4]  = 8'h08; imem[5]  = 8'h30; imem[6]  = 8'h28; imem[7]  = 8'h33;
        imem[8]  = 8'h0F; imem[9]  = 8'h34; imem[10] = 8'h6F; imem[11] = 8'h80;
        imem[12] = 8'hCE; imem[13] = 8'h3C; imem[14] = 8'h90; imem[15] = 8'hCE;
        imem[16] = 8'h10;
        release_reset();
        cycles(4);
        chk("adc_acc", acc, 0);
        chk("adc_carry", carry, 1);
        chk("adc_pc", imem_addr, 2);
        cycles(2);
        chk("jnz_not_taken_pc", imem_addr, 3);
        cycles(2);
        chk("lda_imm_acc", acc, 4'hA);
        run = 1'b0;
        cycles(10);
        chk("hold_pc", imem_addr, 4);
        chk("hold_acc", acc, 4'hA);
        chk("hold_carry", carry, 1);
        run = 1'b1;
        cycles(26);
        chk("prog_halted", halted, 1);
        chk("prog_pc", imem_addr, 5'h11);
        chk("nor_acc", acc, 4'h8);
        chk("nor_carry", carry, 1);
        chk("mem8", dmem[8], 4'hA);
        chk("memF", dmem[15], 4'h3);
        chk("we_pulses", we_cnt, 2);
        cycles(5);
        chk("frozen_pc", imem_addr, 5'h11);

        // PC wraps from 0x1F to 0x00
        hold_reset();
        for (int i = 0; i < 32; i++) imem[i] = 8'h30 | 8'(i & 15);
        release_reset();
        cycles(62);
        chk("wrap_pc_1f", imem_addr, 5'h1F);
        chk("wrap_acc_e", acc, 4'hE);
        cycles(2);
        chk("wrap_pc_0", imem_addr, 0);
        chk("wrap_acc_f", acc, 4'hF);

        // HALT at 0xD ignores run and freezes everything
        hold_reset();
        imem[0]  = 8'hED;
        imem[13] = 8'h10;
        release_reset();
        cycles(4);
        chk("halt_flag", halted, 1);
        chk("halt_pc", imem_addr, 5'h0E);
        run = 1'b0;
        cycles(3);
        run = 1'b1;
        cycles(7);
        chk("halt_frozen_pc", imem_addr, 5'h0E);
        chk("halt_frozen_flag", halted, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
